// File: rtl/arith_cmpf_pipe_if.sv
// Handshake bundle for the floating-point compare pipeline: two operand
// channels joined into one token, plus a single-bit result channel.
interface arith_cmpf_pipe_if #(
  parameter int WIDTH = 32
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [3:0]       pred;
  logic             result_valid;
  logic             result_ready;
  logic             result_data;
  logic             result_unordered;

  // Producer/consumer side (testbench or upstream logic)
  modport master (
    output a_valid, a_data, b_valid, b_data, pred, result_ready,
    input  a_ready, b_ready, result_valid, result_data, result_unordered
  );

  // Compare pipeline side
  modport slave (
    input  a_valid, a_data, b_valid, b_data, pred, result_ready,
    output a_ready, b_ready, result_valid, result_data, result_unordered
  );
endinterface

// File: rtl/arith_cmpf_pipe.sv
// Pipelined IEEE-754 compare (arith.cmpf semantics) for binary16/32/64.
// The compare is done on raw bits in front of stage 0; the STAGES registers
// behind it only carry {valid, result, unordered}. Bubbles collapse so a
// stalled output still lets upstream stages fill.
module arith_cmpf_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  arith_cmpf_pipe_if.slave bus
);

  localparam int EW = (WIDTH == 16) ? 5 : ((WIDTH == 64) ? 11 : 8);
  localparam int MW = WIDTH - 1 - EW;

  generate
    if (!(WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
      $fatal(1, "arith_cmpf_pipe: WIDTH must be 16, 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $fatal(1, "arith_cmpf_pipe: STAGES must be 1..4");
    end
  endgenerate

  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH-2:0]  w_mag_a;
  logic [WIDTH-2:0]  w_mag_b;
  logic              w_sa;
  logic              w_sb;
  logic              w_nan_a;
  logic              w_nan_b;
  logic              w_nan;
  logic              w_both_zero;
  logic              w_eq;
  logic              w_lt;
  logic              w_gt;
  logic              w_rel;
  logic              w_fire;
  logic              w_in_ready;
  logic [STAGES-1:0] w_load;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_res;
  logic [STAGES-1:0] r_unord;

  assign w_a         = bus.a_data;
  assign w_b         = bus.b_data;
  assign w_sa        = w_a[WIDTH-1];
  assign w_sb        = w_b[WIDTH-1];
  assign w_mag_a     = w_a[WIDTH-2:0];
  assign w_mag_b     = w_b[WIDTH-2:0];
  assign w_nan_a     = (&w_a[WIDTH-2:MW]) & (|w_a[MW-1:0]);
  assign w_nan_b     = (&w_b[WIDTH-2:MW]) & (|w_b[MW-1:0]);
  assign w_nan       = w_nan_a | w_nan_b;
  assign w_both_zero = (w_mag_a == '0) && (w_mag_b == '0);

  // Sign-magnitude ordering; +0/-0 collapse to equal, NaN masked later by pred
  always_comb begin
    w_eq = w_both_zero || (w_a == w_b);
    w_lt = 1'b0;
    w_gt = 1'b0;
    if (!w_both_zero) begin
      if (w_sa != w_sb) begin
        w_lt = w_sa;
        w_gt = w_sb;
      end else if (w_sa) begin
        w_lt = w_mag_a > w_mag_b;
        w_gt = w_mag_a < w_mag_b;
      end else begin
        w_lt = w_mag_a < w_mag_b;
        w_gt = w_mag_a > w_mag_b;
      end
    end
  end

  // Predicate decode: 1-6 ordered relations, 8-13 unordered-or relations
  always_comb begin
    w_rel = 1'b0;
    case (bus.pred)
      4'd1:    w_rel = ~w_nan & w_eq;
      4'd2:    w_rel = ~w_nan & w_gt;
      4'd3:    w_rel = ~w_nan & (w_gt | w_eq);
      4'd4:    w_rel = ~w_nan & w_lt;
      4'd5:    w_rel = ~w_nan & (w_lt | w_eq);
      4'd6:    w_rel = ~w_nan & ~w_eq;
      4'd7:    w_rel = ~w_nan;
      4'd8:    w_rel = w_nan | w_eq;
      4'd9:    w_rel = w_nan | w_gt;
      4'd10:   w_rel = w_nan | w_gt | w_eq;
      4'd11:   w_rel = w_nan | w_lt;
      4'd12:   w_rel = w_nan | w_lt | w_eq;
      4'd13:   w_rel = w_nan | ~w_eq;
      4'd14:   w_rel = w_nan;
      4'd15:   w_rel = 1'b1;
      default: w_rel = 1'b0;
    endcase
  end

  // Stage k may load when the output drains or any stage from k onward is empty
  always_comb begin : p_load
    logic v_acc;
    v_acc  = bus.result_ready;
    w_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      v_acc     = v_acc | ~r_valid[k];
      w_load[k] = v_acc;
    end
  end

  // Ready is forced low while reset is held so no handshake is advertised
  assign w_in_ready  = rst_n & w_load[0];
  assign w_fire      = bus.a_valid & bus.b_valid & w_in_ready;
  assign bus.a_ready = w_in_ready & bus.b_valid;
  assign bus.b_ready = w_in_ready & bus.a_valid;

  // Stage registers: stage 0 captures the compare at fire, others shift forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_res   <= '0;
      r_unord <= '0;
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= w_fire;
        if (w_fire) begin
          r_res[0]   <= w_rel;
          r_unord[0] <= w_nan;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_res[k]   <= r_res[k-1];
          r_unord[k] <= r_unord[k-1];
        end
      end
    end
  end

  assign bus.result_valid     = r_valid[STAGES-1];
  assign bus.result_data      = r_res[STAGES-1];
  assign bus.result_unordered = r_unord[STAGES-1];

endmodule

// File: tb/tb_arith_cmpf_pipe.sv
// Directed vector table plus hand sequences (reset, backpressure, mid-flight
// reset, other widths) and a random sweep against an integer-key model.
module tb_arith_cmpf_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arith_cmpf_pipe_if #(.WIDTH(32)) if32 ();
  arith_cmpf_pipe_if #(.WIDTH(64)) if64 ();
  arith_cmpf_pipe_if #(.WIDTH(16)) if16 ();

  arith_cmpf_pipe #(.WIDTH(32), .STAGES(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  arith_cmpf_pipe #(.WIDTH(64), .STAGES(1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
  arith_cmpf_pipe #(.WIDTH(16), .STAGES(3)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  pred;
    logic        exp_res;
    logic        exp_unord;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: map non-NaN values to a signed integer key (-0 and +0 both 0)
  function automatic logic [1:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] p);
    logic   na, nb, un, eq, lt, gt, r;
    longint ka, kb;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    un = na || nb;
    ka = {33'd0, a[30:0]};
    kb = {33'd0, b[30:0]};
    if (a[31]) ka = -ka;
    if (b[31]) kb = -kb;
    eq = (ka == kb);
    lt = (ka < kb);
    gt = (ka > kb);
    case (p)
      4'd0:  r = 1'b0;
      4'd1:  r = !un && eq;
      4'd2:  r = !un && gt;
      4'd3:  r = !un && !lt;
      4'd4:  r = !un && lt;
      4'd5:  r = !un && !gt;
      4'd6:  r = !un && (lt || gt);
      4'd7:  r = !un;
      4'd8:  r = un || eq;
      4'd9:  r = un || gt;
      4'd10: r = un || !lt;
      4'd11: r = un || lt;
      4'd12: r = un || !gt;
      4'd13: r = un || lt || gt;
      4'd14: r = un;
      default: r = 1'b1;
    endcase
    return {un, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 19))
      0:  return 32'h00000000;
      1:  return 32'h80000000;
      2:  return 32'h3F800000;
      3:  return 32'hBF800000;
      4:  return 32'h7F800000;
      5:  return 32'hFF800000;
      6:  return 32'h7FC00000;
      7:  return 32'hFFC00001;
      8:  return 32'h7F800001;
      9:  return 32'h00000001;
      10: return 32'h80000001;
      11: return 32'h007FFFFF;
      12: return 32'h7F7FFFFF;
      13: return 32'h40000000;
      default: return $urandom;
    endcase
  endfunction

  // One token with ready high: check acceptance, STAGES=2 latency and value
  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    if32.a_valid = 1'b1; if32.b_valid = 1'b1;
    if32.a_data = v.a; if32.b_data = v.b; if32.pred = v.pred;
    if32.result_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_fire", idx), if32.a_ready, 1);
    @(posedge clk); #1;
    if32.a_valid = 1'b0; if32.b_valid = 1'b0;
    if32.pred = ~v.pred;
    chk($sformatf("vec%0d_early", idx), if32.result_valid, 0);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_valid", idx), if32.result_valid, 1);
    chk($sformatf("vec%0d_data", idx), if32.result_data, v.exp_res);
    chk($sformatf("vec%0d_unord", idx), if32.result_unordered, v.exp_unord);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [18];
    logic [3:0]  bp_pred [6];
    logic        bp_exp [6];
    logic [1:0]  sb [$];
    logic [1:0]  e;
    int          idx, got, cyc;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 4'd4,  1'b1, 1'b0};
    vecs[1]  = '{32'h7FC00000, 32'h3F800000, 4'd1,  1'b0, 1'b1};
    vecs[2]  = '{32'h7FC00000, 32'h3F800000, 4'd14, 1'b1, 1'b1};
    vecs[3]  = '{32'h7FC00000, 32'h3F800000, 4'd9,  1'b1, 1'b1};
    vecs[4]  = '{32'h00000000, 32'h80000000, 4'd1,  1'b1, 1'b0};
    vecs[5]  = '{32'h00000000, 32'h80000000, 4'd6,  1'b0, 1'b0};
    vecs[6]  = '{32'hBF800000, 32'hC0000000, 4'd2,  1'b1, 1'b0};
    vecs[7]  = '{32'h7F800000, 32'h7F7FFFFF, 4'd2,  1'b1, 1'b0};
    vecs[8]  = '{32'hFF800000, 32'h00000001, 4'd4,  1'b1, 1'b0};
    vecs[9]  = '{32'h00000002, 32'h00000001, 4'd5,  1'b0, 1'b0};
    vecs[10] = '{32'h3F800000, 32'h3F800000, 4'd3,  1'b1, 1'b0};
    vecs[11] = '{32'h3F800000, 32'h3F800000, 4'd13, 1'b0, 1'b0};
    vecs[12] = '{32'h7FC00000, 32'h7FC00000, 4'd7,  1'b0, 1'b1};
    vecs[13] = '{32'h3F800000, 32'h40000000, 4'd0,  1'b0, 1'b0};
    vecs[14] = '{32'h3F800000, 32'h40000000, 4'd15, 1'b1, 1'b0};
    vecs[15] = '{32'h7F800000, 32'h7F800000, 4'd1,  1'b1, 1'b0};
    vecs[16] = '{32'h7F800001, 32'h3F800000, 4'd12, 1'b1, 1'b1};
    vecs[17] = '{32'h80000000, 32'h3F800000, 4'd11, 1'b1, 1'b0};

    bp_pred = '{4'd4, 4'd2, 4'd5, 4'd6, 4'd1, 4'd13};
    bp_exp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    if64.a_valid = 0; if64.b_valid = 0; if64.a_data = 0; if64.b_data = 0;
    if64.pred = 0; if64.result_ready = 1;
    if16.a_valid = 0; if16.b_valid = 0; if16.a_data = 0; if16.b_data = 0;
    if16.pred = 0; if16.result_ready = 1;

    // Reset state with valids asserted: ready must stay low
    if32.a_valid = 1; if32.b_valid = 1;
    if32.a_data = 32'h3F800000; if32.b_data = 32'h40000000; if32.pred = 4'd4;
    if32.result_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", if32.result_valid, 0);
    chk("rst_data", if32.result_data, 0);
    chk("rst_unord", if32.result_unordered, 0);
    chk("rst_a_ready", if32.a_ready, 0);
    chk("rst_b_ready", if32.b_ready, 0);

    // First fire on the first edge after release
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("first_a_ready", if32.a_ready, 1);
    @(posedge clk); #1;
    if32.a_valid = 0; if32.b_valid = 0; if32.pred = 4'd0;
    chk("first_early", if32.result_valid, 0);
    @(posedge clk); #1;
    chk("first_valid", if32.result_valid, 1);
    chk("first_data", if32.result_data, 1);
    chk("first_unord", if32.result_unordered, 0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);
    @(posedge clk); #1;
    chk("drained", if32.result_valid, 0);

    // Backpressure: six tokens, output stalled for five cycles
    idx = 0; got = 0;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk); #1;
      if32.result_ready = (cyc >= 5);
      if32.a_valid = (idx < 6); if32.b_valid = (idx < 6);
      if32.a_data = 32'h3F800000; if32.b_data = 32'h40000000;
      if32.pred = (idx < 6) ? bp_pred[idx] : 4'd0;
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) chk($sformatf("bp_stable%0d", cyc), {if32.result_valid, if32.result_data}, 2'b11);
      if (cyc == 4) begin
        chk("bp_held", idx, 2);
        chk("bp_a_ready", if32.a_ready, 0);
      end
      if (if32.result_valid && if32.result_ready) begin
        if (got < 6) chk($sformatf("bp_order%0d", got), if32.result_data, bp_exp[got]);
        got++;
      end
      if (if32.a_valid && if32.a_ready) idx++;
      if (got >= 6) break;
    end
    chk("bp_accepted", idx, 6);
    chk("bp_results", got, 6);
    @(posedge clk); #1;
    chk("bp_no_dup", if32.result_valid, 0);

    // Reset with two tokens in flight
    if32.result_ready = 1;
    if32.a_valid = 1; if32.b_valid = 1;
    if32.a_data = 32'h3F800000; if32.b_data = 32'h40000000; if32.pred = 4'd2;
    @(posedge clk); #1;
    if32.pred = 4'd4;
    @(posedge clk); #1;
    chk("mid_inflight", if32.result_valid, 1);
    if32.a_data = 32'hC0000000; if32.b_data = 32'hBF800000; if32.pred = 4'd4;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", if32.result_valid, 0);
    chk("mid_rst_data", if32.result_data, 0);
    chk("mid_rst_a_ready", if32.a_ready, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("mid_rel_ready", if32.a_ready, 1);
    @(posedge clk); #1;
    if32.a_valid = 0; if32.b_valid = 0;
    chk("mid_early", if32.result_valid, 0);
    @(posedge clk); #1;
    chk("mid_valid", if32.result_valid, 1);
    chk("mid_data", if32.result_data, 1);
    @(posedge clk); #1;
    chk("mid_drained", if32.result_valid, 0);

    // Random sweep with random valid/ready and a scoreboard queue
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if32.a_valid = ($urandom_range(0, 9) < 7);
      if32.b_valid = ($urandom_range(0, 9) < 7);
      if32.a_data = pick(); if32.b_data = pick();
      if32.pred = 4'($urandom_range(0, 15));
      if32.result_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (if32.result_valid && if32.result_ready) begin
        if (sb.size() == 0) chk("sweep_extra", 1, 0);
        else begin
          e = sb.pop_front();
          chk($sformatf("sweep%0d", c), {if32.result_unordered, if32.result_data}, e);
        end
      end
      if (if32.a_valid && if32.a_ready)
        sb.push_back(ref32(if32.a_data, if32.b_data, if32.pred));
    end
    @(posedge clk); #1;
    if32.a_valid = 0; if32.b_valid = 0; if32.result_ready = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if32.result_valid) begin
        if (sb.size() == 0) chk("sweep_extra", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sweep_drain", {if32.result_unordered, if32.result_data}, e);
        end
      end
    end
    chk("sweep_left", sb.size(), 0);

    // binary64, one stage
    @(posedge clk); #1;
    if64.a_valid = 1; if64.b_valid = 1;
    if64.a_data = 64'h0000000000000000; if64.b_data = 64'h8000000000000000; if64.pred = 4'd1;
    @(negedge clk);
    chk("w64_fire", if64.a_ready, 1);
    @(posedge clk); #1;
    chk("w64_valid", if64.result_valid, 1);
    chk("w64_zero_eq", if64.result_data, 1);
    if64.a_data = 64'h7FF8000000000000; if64.b_data = 64'h3FF0000000000000; if64.pred = 4'd14;
    @(posedge clk); #1;
    if64.a_valid = 0; if64.b_valid = 0;
    chk("w64_uno", if64.result_data, 1);
    chk("w64_unord", if64.result_unordered, 1);
    @(posedge clk); #1;
    chk("w64_drained", if64.result_valid, 0);

    // binary16, three stages
    @(posedge clk); #1;
    if16.a_valid = 1; if16.b_valid = 1;
    if16.a_data = 16'hBC00; if16.b_data = 16'h3C00; if16.pred = 4'd4;
    @(posedge clk); #1;
    if16.a_valid = 0; if16.b_valid = 0;
    @(posedge clk); #1;
    chk("w16_early", if16.result_valid, 0);
    @(posedge clk); #1;
    chk("w16_valid", if16.result_valid, 1);
    chk("w16_lt", if16.result_data, 1);
    chk("w16_unord", if16.result_unordered, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_cmpf_pipe.md
ARITH_CMPF_PIPE -- requirements
Module: arith_cmpf_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values 16 (binary16), 32 (binary32), 64 (binary64).
REQ-002 SHALL have parameter STAGES, default 2, pipeline register depth; legal 1..4.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports a_valid  input  1, a_ready  output  1, a_data  input  WIDTH; operand A channel.
REQ-007 SHALL have ports b_valid  input  1, b_ready  output  1, b_data  input  WIDTH; operand B channel.
REQ-008 SHALL have port pred  input  4  per-token predicate, MLIR arith.cmpf encoding 0=false..15=true; sampled with operands.
REQ-009 SHALL have ports result_valid  output  1, result_ready  input  1, result_data  output  1; result channel.
REQ-010 SHALL have port result_unordered  output  1  set when either operand of the presented result was NaN.
REQ-011 SHALL fail elaboration with $fatal for illegal WIDTH or STAGES.

Function
REQ-012 Comparison SHALL be bit-level and synthesizable: no real/shortreal types.
REQ-013 NaN: exponent all ones and mantissa nonzero; is_nan = nan(A) | nan(B).
REQ-014 +0 and -0 SHALL compare equal; infinities ordered normally; denormals compared by magnitude.
REQ-015 Ordering: sign-magnitude; both positive -> magnitude compare; both negative -> inverted magnitude; mixed signs -> negative is less unless both zero.
REQ-016 Predicates 1-6 SHALL be !is_nan & relation; 8-13 SHALL be is_nan | relation; 7=!is_nan; 14=is_nan; 0=0; 15=1.
REQ-017 Join: token accepted (fire) iff a_valid & b_valid & in_ready; a_ready = in_ready & b_valid; b_ready = in_ready & a_valid.
REQ-018 in_ready = !stage0_valid | stage0_advance; no combinational path from a_valid to a_ready or b_valid to b_ready.
REQ-019 Each stage k SHALL hold valid, result bit and unordered bit; stage k loads from k-1 when empty or when advancing.
REQ-020 Final stage advances when result_ready; intermediate stages advance when next stage empty or advancing (bubbles collapse).
REQ-021 Latency: result_valid exactly STAGES cycles after fire with result_ready held high.
REQ-022 Throughput: one token per cycle sustained with result_ready high.
REQ-023 Under backpressure the pipeline SHALL hold up to STAGES tokens, lose none, preserve order, and keep result_data stable while result_valid & !result_ready.
REQ-024 Simultaneous fire and final-stage drain on a full pipeline SHALL both occur in the same cycle.
REQ-025 pred SHALL be captured at fire; later pred changes SHALL not affect in-flight tokens.

Reset
REQ-026 While rst_n low: all stage valids 0, result_valid 0, result_data 0, result_unordered 0, a_ready 0, b_ready 0.
REQ-027 Reset assertion mid-operation SHALL discard all in-flight tokens immediately (asynchronous).
REQ-028 First fire possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 WIDTH=32, STAGES=2, pred=4, A=0x3F800000, B=0x40000000, ready high -> result_data=1, result_unordered=0, 2 cycles after fire.
REQ-030 WIDTH=32, A=0x7FC00000, B=0x3F800000: pred=1 -> 0, pred=14 -> 1, pred=9 -> 1; result_unordered=1 all three.
REQ-031 WIDTH=64, pred=1, A=0x0000000000000000, B=0x8000000000000000 -> result_data=1; WIDTH=16, pred=4, A=0xBC00, B=0x3C00 -> 1.
REQ-032 STAGES=2, 6 back-to-back tokens, result_ready low 5 cycles: a_ready low after 2 tokens held; on release all 6 results in order, none lost or duplicated.
REQ-033 Reset pulse with 2 tokens in flight -> result_valid 0 same cycle; after release next token's result has correct value and latency.
REQ-034 Random sweep: all 16 predicates, NaN/Inf/zero/denormal corners, random valid/ready -> matches bit-level reference model, one result per fire.
